// File: rtl/motion_bbox_detect.sv
// Motion bounding-box detector: any non-zero difference pixel counts as motion; one box is published per frame.
// Optional BBOX_OVERLAY_EN draws the last published box onto the forwarded stream.
module motion_bbox_detect #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int CNT_W      = 12,
  parameter int MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               per_img_vsync,
  input  logic               per_img_hsync,
  input  logic               per_img_valid,
  input  logic [7:0]         per_img_data,
  output logic               post_img_vsync,
  output logic               post_img_hsync,
  output logic               post_img_valid,
  output logic [7:0]         post_img_data,
  output logic               bbox_valid,
  output logic               bbox_found,
  output logic [CNT_W-1:0]   bbox_x_min,
  output logic [CNT_W-1:0]   bbox_x_max,
  output logic [CNT_W-1:0]   bbox_y_min,
  output logic [CNT_W-1:0]   bbox_y_max,
  output logic [2*CNT_W-1:0] bbox_pix_cnt
);

  localparam logic [CNT_W-1:0]   LP_W   = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0]   LP_H   = CNT_W'(IMG_H);
  localparam logic [2*CNT_W-1:0] LP_MIN = (2*CNT_W)'(MIN_PIXELS);

  logic               r_vsync, r_hsync, r_valid, r_sync_ok, r_armed;
  logic [7:0]         r_data;
  logic [CNT_W-1:0]   r_x_cnt, r_y_cnt;
  logic [CNT_W-1:0]   r_x_min, r_x_max, r_y_min, r_y_max;
  logic [2*CNT_W-1:0] r_pix_cnt;
  logic               r_bbox_valid, r_bbox_found;
  logic [CNT_W-1:0]   r_bx_x_min, r_bx_x_max, r_bx_y_min, r_bx_y_max;
  logic [2*CNT_W-1:0] r_bbox_pix_cnt;

  logic w_frame_start, w_frame_end, w_line_end, w_motion, w_publish;

  // r_sync_ok blocks a false frame start when reset releases in the middle of a frame
  assign w_frame_start = per_img_vsync & ~r_vsync & r_sync_ok;
  assign w_frame_end   = ~per_img_vsync & r_vsync;
  assign w_line_end    = ~per_img_hsync & r_hsync;
  assign w_publish     = w_frame_end & r_armed;
  assign w_motion      = per_img_valid & per_img_vsync & (|per_img_data) &
                         (r_x_cnt < LP_W) & (r_y_cnt < LP_H) & r_armed;

`ifdef BBOX_OVERLAY_EN
  logic w_in_x, w_in_y, w_border;
  assign w_in_x   = (r_x_cnt >= r_bx_x_min) & (r_x_cnt <= r_bx_x_max);
  assign w_in_y   = (r_y_cnt >= r_bx_y_min) & (r_y_cnt <= r_bx_y_max);
  assign w_border = (((r_x_cnt == r_bx_x_min) | (r_x_cnt == r_bx_x_max)) & w_in_y) |
                    (((r_y_cnt == r_bx_y_min) | (r_y_cnt == r_bx_y_max)) & w_in_x);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync   <= 1'b0;
      r_hsync   <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= 8'd0;
      r_sync_ok <= 1'b0;
    end else begin
      r_vsync   <= per_img_vsync;
      r_hsync   <= per_img_hsync;
      r_valid   <= per_img_valid;
      r_sync_ok <= r_sync_ok | ~per_img_vsync;
`ifdef BBOX_OVERLAY_EN
      r_data    <= (per_img_valid & w_border & r_bbox_found) ? 8'hFF : per_img_data;
`else
      r_data    <= per_img_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else begin
      if (w_line_end)
        r_x_cnt <= '0;
      else if (per_img_valid & per_img_vsync & ~(&r_x_cnt))
        r_x_cnt <= r_x_cnt + 1'b1;
      if (w_frame_start)
        r_y_cnt <= '0;
      else if (w_line_end & ~(&r_y_cnt))
        r_y_cnt <= r_y_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_armed <= 1'b0;
    else if (w_frame_start)
      r_armed <= 1'b1;
    else if (w_publish)
      r_armed <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst | w_frame_start) begin
      r_x_min   <= '1;
      r_y_min   <= '1;
      r_x_max   <= '0;
      r_y_max   <= '0;
      r_pix_cnt <= '0;
    end else if (w_motion) begin
      if (r_x_cnt < r_x_min) r_x_min <= r_x_cnt;
      if (r_x_cnt > r_x_max) r_x_max <= r_x_cnt;
      if (r_y_cnt < r_y_min) r_y_min <= r_y_cnt;
      if (r_y_cnt > r_y_max) r_y_max <= r_y_cnt;
      if (~(&r_pix_cnt)) r_pix_cnt <= r_pix_cnt + 1'b1;
    end
  end

  // Frames below the pixel threshold publish a zero box but keep the real count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bbox_valid   <= 1'b0;
      r_bbox_found   <= 1'b0;
      r_bx_x_min     <= '0;
      r_bx_x_max     <= '0;
      r_bx_y_min     <= '0;
      r_bx_y_max     <= '0;
      r_bbox_pix_cnt <= '0;
    end else begin
      r_bbox_valid <= w_publish;
      if (w_publish) begin
        r_bbox_pix_cnt <= r_pix_cnt;
        if (r_pix_cnt >= LP_MIN) begin
          r_bbox_found <= 1'b1;
          r_bx_x_min   <= r_x_min;
          r_bx_x_max   <= r_x_max;
          r_bx_y_min   <= r_y_min;
          r_bx_y_max   <= r_y_max;
        end else begin
          r_bbox_found <= 1'b0;
          r_bx_x_min   <= '0;
          r_bx_x_max   <= '0;
          r_bx_y_min   <= '0;
          r_bx_y_max   <= '0;
        end
      end
    end
  end

  assign post_img_vsync = r_vsync;
  assign post_img_hsync = r_hsync;
  assign post_img_valid = r_valid;
  assign post_img_data  = r_data;
  assign bbox_valid     = r_bbox_valid;
  assign bbox_found     = r_bbox_found;
  assign bbox_x_min     = r_bx_x_min;
  assign bbox_x_max     = r_bx_x_max;
  assign bbox_y_min     = r_bx_y_min;
  assign bbox_y_max     = r_bx_y_max;
  assign bbox_pix_cnt   = r_bbox_pix_cnt;

endmodule

// File: tb/tb_motion_bbox_detect.sv
// Scoreboard bench for motion_bbox_detect: directed frames with hand-computed boxes, stream checked pixel by pixel.
module tb_motion_bbox_detect;

  localparam int CW = 12;
  localparam int PA = 0, PF = 1, PB = 2, PC = 3, PD = 4, PE = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          per_img_vsync, per_img_hsync, per_img_valid;
  logic [7:0]    per_img_data;
  logic          post_img_vsync, post_img_hsync, post_img_valid;
  logic [7:0]    post_img_data;
  logic          bbox_valid, bbox_found;
  logic [CW-1:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [2*CW-1:0] bbox_pix_cnt;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_pulses = 0;
  logic chk_en   = 1'b0;
  int   pat;
  logic ov_found = 1'b0;
  int   ov_x0, ov_x1, ov_y0, ov_y1;

  logic [72:0] exp_box_q[$];
  logic [9:0]  exp_px_q[$];

  motion_bbox_detect #(
    .IMG_W(8), .IMG_H(4), .CNT_W(CW), .MIN_PIXELS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .per_img_vsync(per_img_vsync), .per_img_hsync(per_img_hsync),
    .per_img_valid(per_img_valid), .per_img_data(per_img_data),
    .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
    .post_img_valid(post_img_valid), .post_img_data(post_img_data),
    .bbox_valid(bbox_valid), .bbox_found(bbox_found),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
    .bbox_pix_cnt(bbox_pix_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    logic [7:0] d;
    d = 8'd0;
    case (pat)
      PA: if (x >= 2 && x <= 5 && y >= 1 && y <= 2) d = 8'd80;
      PF: d = 8'd10;
      PC: if ((x == 1 && y == 1) || (x == 6 && y == 3) || (x == 3 && y == 0)) d = 8'h33;
      PD: if (x >= 8 || y >= 4) d = 8'h77;
      PE: if ((x == 0 && y == 0) || (x == 7 && y == 3) || (x == 3 && y == 1) || (x == 4 && y == 2)) d = 8'h01;
      default: d = 8'd0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] exp_pix(input int x, input int y, input logic [7:0] d);
    logic [7:0] r;
    r = d;
`ifdef BBOX_OVERLAY_EN
    if (ov_found &&
        (((x == ov_x0 || x == ov_x1) && y >= ov_y0 && y <= ov_y1) ||
         ((y == ov_y0 || y == ov_y1) && x >= ov_x0 && x <= ov_x1)))
      r = 8'hFF;
`endif
    return r;
  endfunction

  // driver tasks
  task automatic push_box(input logic f, input int x0, input int x1, input int y0, input int y1, input int cnt);
    exp_box_q.push_back({f, CW'(x0), CW'(x1), CW'(y0), CW'(y1), (2*CW)'(cnt)});
  endtask

  task automatic drive_frame(input int w, input int h, input int p, input logic rst_mid);
    pat = p;
    tick();
    per_img_vsync = 1'b1;
    for (int y = 0; y < h; y++) begin
      if (rst_mid && y == 2) begin
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_mid_outputs",
            64'({post_img_vsync, post_img_hsync, post_img_valid, post_img_data, bbox_valid,
                 bbox_found, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} != '0) |
            64'(bbox_pix_cnt), 64'd0);
        rst = 1'b0;
      end
      for (int x = 0; x < w; x++) begin
        tick();
        per_img_hsync = 1'b1;
        per_img_valid = 1'b1;
        per_img_data  = pix(x, y);
        if (chk_en) exp_px_q.push_back({1'b1, 1'b1, exp_pix(x, y, per_img_data)});
      end
      tick();
      per_img_hsync = 1'b0;
      per_img_valid = 1'b0;
      per_img_data  = 8'd0;
    end
    tick();
    tick();
    per_img_vsync = 1'b0;
    repeat (3) tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [9:0]  e;
    logic [72:0] b;
    if (!rst && chk_en && post_img_valid) begin
      if (exp_px_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL stream_extra: got data %0h expected no pixel", post_img_data);
      end else begin
        e = exp_px_q.pop_front();
        chk("stream", 64'({post_img_vsync, post_img_hsync, post_img_data}), 64'(e));
      end
    end
    if (bbox_valid) begin
      n_pulses++;
      if (exp_box_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL bbox_extra: got pulse cnt=%0d expected no publish", bbox_pix_cnt);
      end else begin
        b = exp_box_q.pop_front();
        chk("bbox_found", 64'(bbox_found), 64'(b[72]));
        chk("bbox_x_min", 64'(bbox_x_min), 64'(b[71:60]));
        chk("bbox_x_max", 64'(bbox_x_max), 64'(b[59:48]));
        chk("bbox_y_min", 64'(bbox_y_min), 64'(b[47:36]));
        chk("bbox_y_max", 64'(bbox_y_max), 64'(b[35:24]));
        chk("bbox_pix_cnt", 64'(bbox_pix_cnt), 64'(b[23:0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    per_img_vsync = 1'b0;
    per_img_hsync = 1'b0;
    per_img_valid = 1'b0;
    per_img_data  = 8'd0;
    repeat (3) tick();
    chk("reset_stream", 64'({post_img_vsync, post_img_hsync, post_img_valid, post_img_data}), 64'd0);
    chk("reset_bbox", 64'({bbox_valid, bbox_found, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} != '0), 64'd0);
    chk("reset_cnt", 64'(bbox_pix_cnt), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // frame interrupted by reset: must publish nothing
    chk_en = 1'b0;
    drive_frame(8, 4, PA, 1'b1);
    chk_en = 1'b1;
    chk("after_reset_frame_cnt", 64'({bbox_found, bbox_pix_cnt}), 64'd0);

    ov_found = 1'b0;
    push_box(1'b1, 2, 5, 1, 2, 8);
    drive_frame(8, 4, PA, 1'b0);
    repeat (4) tick();
    chk("hold_x_max", 64'(bbox_x_max), 64'd5);
    chk("hold_y_min", 64'(bbox_y_min), 64'd1);

    ov_found = 1'b1; ov_x0 = 2; ov_x1 = 5; ov_y0 = 1; ov_y1 = 2;
    push_box(1'b1, 0, 7, 0, 3, 32);
    drive_frame(8, 4, PF, 1'b0);

    ov_found = 1'b1; ov_x0 = 0; ov_x1 = 7; ov_y0 = 0; ov_y1 = 3;
    push_box(1'b0, 0, 0, 0, 0, 0);
    drive_frame(8, 4, PB, 1'b0);

    ov_found = 1'b0;
    push_box(1'b0, 0, 0, 0, 0, 3);
    drive_frame(8, 4, PC, 1'b0);

    push_box(1'b0, 0, 0, 0, 0, 0);
    drive_frame(10, 5, PD, 1'b0);

    // lone pixel outside any frame: forwarded, never counted
    tick();
    per_img_valid = 1'b1;
    per_img_data  = 8'h5A;
    exp_px_q.push_back({1'b0, 1'b0, 8'h5A});
    tick();
    per_img_valid = 1'b0;
    per_img_data  = 8'd0;
    repeat (2) tick();

    push_box(1'b1, 0, 7, 0, 3, 4);
    drive_frame(8, 4, PE, 1'b0);
    repeat (5) tick();
    chk("hold_found", 64'(bbox_found), 64'd1);
    chk("hold_pix_cnt", 64'(bbox_pix_cnt), 64'd4);
    chk("publish_pulses", 64'(n_pulses), 64'd6);
    chk("stream_q_empty", 64'(exp_px_q.size()), 64'd0);
    chk("bbox_q_empty", 64'(exp_box_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
